// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared funct3 codes, LSU state encoding and byte-mask constants.
// Revision: 1.0
`default_nettype none

package msrv32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_e;

  localparam logic [3:0] MASK_NONE    = 4'b0000;
  localparam logic [3:0] MASK_BYTE0   = 4'b0001;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_WORD    = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/msrv32_load_extract.sv
// msrv32_load_extract: selects the addressed byte/halfword of a read word and extends it.
// Revision: 1.0
`default_nettype none

module msrv32_load_extract
  import msrv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/msrv32_lsu.sv
// msrv32_lsu: load/store unit with single-outstanding req/ack data bus and load extension.
// Revision: 1.0 -- optional bus timeout enabled by MSRV32_LSU_TIMEOUT_EN.
`default_nettype none

module msrv32_lsu
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_op_valid_in,
  input  logic        mem_wr_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] rs2_in,
  output logic        dmem_req_out,
  output logic        dmem_wr_req_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wr_mask_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  lsu_state_e  state;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        misaligned;
  logic        accept;
  logic        timeout_hit;
  logic [31:0] ext_data;
  logic [31:0] st_wdata;
  logic [3:0]  st_mask;

  assign misaligned = mem_op_valid_in &&
                      ((funct3_in[1:0] == 2'b01 && addr_in[0]) ||
                       (funct3_in[1:0] == 2'b10 && addr_in[1:0] != 2'b00));
  assign accept         = mem_op_valid_in && !misaligned;
  assign misaligned_out = (state == IDLE) && misaligned;
  assign stall_out      = ((state == IDLE) && accept) ||
                          ((state == BUSY) && !dmem_ack_in && !timeout_hit);

  // Store lanes are replicated so the mask alone picks the written bytes.
  always_comb begin
    case (funct3_in)
      F3_SB: begin
        st_wdata = {4{rs2_in[7:0]}};
        st_mask  = MASK_BYTE0 << addr_in[1:0];
      end
      F3_SH: begin
        st_wdata = {2{rs2_in[15:0]}};
        st_mask  = addr_in[1] ? MASK_HALF_HI : MASK_HALF_LO;
      end
      default: begin
        st_wdata = rs2_in;
        st_mask  = MASK_WORD;
      end
    endcase
  end

  msrv32_load_extract u_extract (
    .rdata  (dmem_rdata_in),
    .funct3 (funct3_q),
    .offset (offset_q),
    .data   (ext_data)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state            <= IDLE;
      funct3_q         <= 3'd0;
      offset_q         <= 2'd0;
      dmem_req_out     <= 1'b0;
      dmem_wr_req_out  <= 1'b0;
      dmem_addr_out    <= 32'd0;
      dmem_wdata_out   <= 32'd0;
      dmem_wr_mask_out <= 4'd0;
      load_data_out    <= 32'd0;
      load_valid_out   <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state            <= BUSY;
            funct3_q         <= funct3_in;
            offset_q         <= addr_in[1:0];
            dmem_req_out     <= 1'b1;
            dmem_wr_req_out  <= mem_wr_in;
            dmem_addr_out    <= {addr_in[31:2], 2'b00};
            dmem_wdata_out   <= st_wdata;
            dmem_wr_mask_out <= mem_wr_in ? st_mask : MASK_NONE;
          end
        end
        BUSY: begin
          if (dmem_ack_in) begin
            state           <= IDLE;
            dmem_req_out    <= 1'b0;
            dmem_wr_req_out <= 1'b0;
            if (!dmem_wr_req_out) begin
              load_data_out  <= ext_data;
              load_valid_out <= 1'b1;
            end
          end else if (timeout_hit) begin
            state           <= IDLE;
            dmem_req_out    <= 1'b0;
            dmem_wr_req_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MSRV32_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] busy_cnt;

  // Fires in the TIMEOUT_CYCLES-th unacknowledged BUSY cycle; ack wins.
  assign timeout_hit = (state == BUSY) && !dmem_ack_in && (busy_cnt == CNT_LIMIT);

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      busy_cnt    <= '0;
      bus_err_out <= 1'b0;
    end else begin
      bus_err_out <= 1'b0;
      if (state == IDLE && accept) begin
        busy_cnt <= '0;
      end else if (state == BUSY && !dmem_ack_in) begin
        if (timeout_hit) bus_err_out <= 1'b1;
        else             busy_cnt    <= busy_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_msrv32_lsu.sv
// tb_msrv32_lsu: directed self-checking bench with a load-result scoreboard.
// Revision: 1.0
`default_nettype none

module tb_msrv32_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        req, wr_req, load_valid, stall, misaligned, bus_err;
  logic [31:0] maddr, wdata, load_data;
  logic [3:0]  mask;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  msrv32_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .mem_op_valid_in      (valid),
    .mem_wr_in            (wr),
    .funct3_in            (f3),
    .addr_in              (addr),
    .rs2_in               (rs2),
    .dmem_req_out         (req),
    .dmem_wr_req_out      (wr_req),
    .dmem_addr_out        (maddr),
    .dmem_wdata_out       (wdata),
    .dmem_wr_mask_out     (mask),
    .dmem_ack_in          (ack),
    .dmem_rdata_in        (rdata),
    .load_data_out        (load_data),
    .load_valid_out       (load_valid),
    .stall_out            (stall),
    .misaligned_out       (misaligned),
    .bus_err_out          (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every load_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (load_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load_valid", 32'd1, 32'd0);
      end else begin
        check("load_data", load_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One aligned operation: accept cycle, `waits` unacked BUSY cycles, then the ack cycle.
  task automatic do_op(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input int waits, input logic [31:0] rd,
                       input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    valid = 1'b1; wr = w; f3 = f; addr = a; rs2 = d;
    @(negedge clk);
    check({tag, "_accept_stall"}, 32'(stall), 32'd1);
    check({tag, "_accept_misaligned"}, 32'(misaligned), 32'd0);
    step();
    valid = 1'b0; rs2 = 32'h0BAD_0BAD; addr = 32'hFFFF_FFFF;
    rdata = 32'h5555_AAAA;
    @(negedge clk);
    check({tag, "_req"}, 32'(req), 32'd1);
    check({tag, "_wr_req"}, 32'(wr_req), 32'(w));
    check({tag, "_addr"}, maddr, exp_addr);
    check({tag, "_mask"}, 32'(mask), 32'(exp_mask));
    if (w) check({tag, "_wdata"}, wdata, exp_wdata);
    for (int i = 0; i < waits; i++) begin
      check({tag, "_busy_stall"}, 32'(stall), 32'd1);
      step();
      @(negedge clk);
      check({tag, "_busy_req_held"}, 32'(req), 32'd1);
      check({tag, "_busy_addr_held"}, maddr, exp_addr);
    end
    ack = 1'b1; rdata = rd;
    if (!w) exp_q.push_back(exp_load);
    #1;
    check({tag, "_ack_stall"}, 32'(stall), 32'd0);
    step();
    ack = 1'b0; rdata = 32'h0;
    @(negedge clk);
    check({tag, "_done_req"}, 32'(req), 32'd0);
    check({tag, "_load_valid"}, 32'(load_valid), 32'(!w));
    check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    step();
    @(negedge clk);
    check({tag, "_load_valid_pulse"}, 32'(load_valid), 32'd0);
    step();
  endtask

  task automatic misaligned_op(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a);
    valid = 1'b1; wr = w; f3 = f; addr = a; rs2 = 32'h1111_2222;
    @(negedge clk);
    check({tag, "_misaligned"}, 32'(misaligned), 32'd1);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    step();
    valid = 1'b0;
    @(negedge clk);
    check({tag, "_req"}, 32'(req), 32'd0);
    step();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(req), 32'd0);
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_addr", maddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_mask", 32'(mask), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Stores
    do_op("sw", 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 3, 32'h0,
          32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    do_op("sb", 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 32'h0,
          32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    do_op("sh_hi", 1'b1, 3'b001, 32'h0000_0212, 32'h7777_BEAD, 1, 32'h0,
          32'h0000_0210, 4'b1100, 32'hBEAD_BEAD, 32'h0);
    do_op("sw_f3_111", 1'b1, 3'b111, 32'h0000_0220, 32'h0102_0304, 0, 32'h0,
          32'h0000_0220, 4'b1111, 32'h0102_0304, 32'h0);

    // Loads
    do_op("lb", 1'b0, 3'b000, 32'h0000_0301, 32'h0, 0, 32'h1234_F600,
          32'h0000_0300, 4'b0000, 32'h0, 32'hFFFF_FFF6);
    do_op("lbu", 1'b0, 3'b100, 32'h0000_0301, 32'h0, 2, 32'h1234_F600,
          32'h0000_0300, 4'b0000, 32'h0, 32'h0000_00F6);
    do_op("lhu", 1'b0, 3'b101, 32'h0000_0302, 32'h0, 0, 32'h8001_5A5A,
          32'h0000_0300, 4'b0000, 32'h0, 32'h0000_8001);
    do_op("lh", 1'b0, 3'b001, 32'h0000_0302, 32'h0, 0, 32'h8001_5A5A,
          32'h0000_0300, 4'b0000, 32'h0, 32'hFFFF_8001);
    do_op("lw", 1'b0, 3'b010, 32'h0000_0304, 32'h0, 1, 32'hCAFE_F00D,
          32'h0000_0304, 4'b0000, 32'h0, 32'hCAFE_F00D);

    // Misaligned
    misaligned_op("mis_lw", 1'b0, 3'b010, 32'h0000_0102);
    misaligned_op("mis_sh", 1'b1, 3'b001, 32'h0000_0101);

    // Reset while BUSY
    valid = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h0000_0400;
    step();
    valid = 1'b0;
    @(negedge clk);
    check("rstbusy_req_before", 32'(req), 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("rstbusy_req_dropped", 32'(req), 32'd0);
    ack = 1'b1; rdata = 32'h9999_9999;
    repeat (2) begin
      @(negedge clk);
      check("rstbusy_load_valid", 32'(load_valid), 32'd0);
      check("rstbusy_stall", 32'(stall), 32'd0);
      step();
    end
    ack = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rstbusy_idle_req", 32'(req), 32'd0);
    check("rstbusy_idle_lv", 32'(load_valid), 32'd0);
    step();
    do_op("lw_after_rst", 1'b0, 3'b010, 32'h0000_0500, 32'h0, 0, 32'h0BEE_F00D,
          32'h0000_0500, 4'b0000, 32'h0, 32'h0BEE_F00D);

`ifdef MSRV32_LSU_TIMEOUT_EN
    // Timeout with no ack
    valid = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h0000_0600;
    step();
    valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("to_req", 32'(req), 32'd1);
      check("to_stall", 32'(stall), (i == 4) ? 32'd0 : 32'd1);
      check("to_bus_err_early", 32'(bus_err), 32'd0);
      step();
    end
    @(negedge clk);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_req_dropped", 32'(req), 32'd0);
    check("to_no_load_valid", 32'(load_valid), 32'd0);
    step();
    @(negedge clk);
    check("to_bus_err_pulse", 32'(bus_err), 32'd0);
    step();
    // Ack in the limit cycle completes normally
    do_op("to_ack_at_limit", 1'b0, 3'b010, 32'h0000_0700, 32'h0, 3, 32'h1357_9BDF,
          32'h0000_0700, 4'b0000, 32'h0, 32'h1357_9BDF);
`endif

    repeat (2) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/msrv32_lsu.md
Name: msrv32_lsu

Overview:
- Load/store unit directly downstream of msrv32_alu; consumes the ALU result as the effective address for loads and stores.
- Aligns store data and byte-enables, and issues one request at a time on the data-memory bus with a req/ack handshake.
- Stalls the pipeline until the bus acknowledges.
- Extracts and sign/zero-extends load data for the writeback stage.

Parameters:
TIMEOUT_CYCLES, 255, maximum BUSY cycles without dmem_ack_in before abort (used only with the optional feature); counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
ms_riscv32_mp_clk_in  in  1  clock, rising edge
ms_riscv32_mp_rst_in  in  1  asynchronous active-high reset
mem_op_valid_in  in  1  load/store present this cycle
mem_wr_in  in  1  1=store, 0=load
funct3_in  in  3  RV32I width/sign field
addr_in  in  32  effective address from ALU result_out
rs2_in  in  32  store data
dmem_req_out  out  1  bus request
dmem_wr_req_out  out  1  request is a store
dmem_addr_out  out  32  word-aligned address
dmem_wdata_out  out  32  lane-replicated store data
dmem_wr_mask_out  out  4  byte enables, stores only
dmem_ack_in  in  1  bus acknowledge/data valid
dmem_rdata_in  in  32  read word
load_data_out  out  32  extended load result
load_valid_out  out  1  one-cycle pulse, load_data_out valid
stall_out  out  1  hold upstream stages
misaligned_out  out  1  misaligned-access flag (combinational)
bus_err_out  out  1  one-cycle timeout pulse

Behaviour:
- Reset:
  - state=IDLE.
  - All registered outputs 0: dmem_* outputs, load_data_out, load_valid_out, bus_err_out.
  - Reset mid-operation drops dmem_req_out immediately; no load_valid_out is produced.
- Misalignment: misaligned = valid && ((funct3[1:0]==01 && addr[0]) || (funct3[1:0]==10 && addr[1:0]!=0)).
  - misaligned_out = IDLE && misaligned.
  - No bus request, no stall; upstream handles the trap.
- States:
  - IDLE: valid and not misaligned -> register address, wdata, mask, funct3, addr[1:0] and wr; next state BUSY.
  - BUSY: dmem_req_out=1 and all dmem_* outputs held stable.
    - dmem_ack_in -> IDLE; for a load, register the extracted data and pulse load_valid_out on the following cycle.
- stall_out (combinational) = (IDLE && valid && !misaligned) || (BUSY && !dmem_ack_in).
  - Stall falls in the ack cycle, so upstream advances at that edge.
  - Minimum operation: 1 accept cycle + 1 BUSY cycle. Ack-to-load_valid latency is 1 cycle.
- Store alignment; dmem_addr_out = {addr[31:2],2'b00}:
  - SB (000): wdata={4{rs2[7:0]}}, mask=4'b0001<<addr[1:0].
  - SH (001): wdata={2{rs2[15:0]}}, mask=addr[1]?1100:0011.
  - SW (010): wdata=rs2, mask=1111.
  - Other store funct3 values are treated as SW.
- Loads: mask=0000.
  - LB (000) / LBU (100): byte at offset, sign/zero-extended.
  - LH (001) / LHU (101): halfword at addr[1], sign/zero-extended.
  - LW (010): full word.
  - 011/110/111 are treated as LW.
- dmem_ack_in in IDLE is ignored.

Optional Feature:
- MSRV32_LSU_TIMEOUT_EN defined:
  - The counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - On reaching TIMEOUT_CYCLES without ack: state -> IDLE, bus_err_out pulses one cycle, no load_valid_out, stall released that cycle.
  - Ack in the same cycle as the limit takes priority: normal completion, no error.
- Not defined: no counter; BUSY waits indefinitely; bus_err_out tied 0.

Decomposition:
- msrv32_pkg holds:
  - funct3 constants: LB/LH/LW/LBU/LHU, SB/SH/SW.
  - LSU state encoding: IDLE=1'b0, BUSY=1'b1.
  - Byte-mask constants.
- One combinational sub-module, msrv32_load_extract: inputs rdata, funct3, offset[1:0]; output is the 32-bit extended value.

Test Plan:
1. SW addr=0x100, rs2=0xDEADBEEF; ack after 3 BUSY cycles -> dmem_addr_out=0x100, mask=1111, wdata=0xDEADBEEF; stall high 3 cycles then low in the ack cycle; no load_valid_out.
2. SB addr=0x203, rs2=0x000000A5 -> dmem_addr_out=0x200, mask=1000, wdata=0xA5A5A5A5.
3. LB addr=0x301, rdata=0x1234F600, ack -> load_data_out=0xFFFFFFF6 with load_valid_out one cycle after ack. LBU with the same inputs -> 0x000000F6. LHU addr=0x302, rdata=0x8001xxxx -> 0x00008001.
4. LW addr=0x102 -> misaligned_out=1, stall_out=0, dmem_req_out stays 0. SH addr=0x101 -> same response.
5. Load in BUSY, assert reset, release after 2 cycles -> dmem_req_out=0 immediately, state IDLE, load_valid_out never pulses; next LW completes normally.
6. With MSRV32_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> bus_err_out pulses after 4 BUSY cycles, stall drops, req drops. Ack exactly at cycle 4 -> normal completion, bus_err_out=0.
